// File: rtl/fpga_core_pkg.sv
// rtl/fpga_core_pkg.sv - fabric geometry, config field offsets and driver decode
package fpga_core_pkg;

    localparam int N_TILES     = 64;
    localparam int TILE_BITS   = 69;
    localparam int CFG_BITS    = N_TILES * TILE_BITS;
    localparam int IO_BITS     = 128;
    localparam int POOL_BITS   = 256;
    localparam int POOL_Q_BASE = 128;

    localparam int DRV_A_LSB   = 0;
    localparam int DRV_B_LSB   = 10;
    localparam int DRV_BITS    = 10;
    localparam int SEL_LSB     = 20;
    localparam int SEL_BITS    = 8;
    localparam int TRUTH_LSB   = 52;
    localparam int TRUTH_BITS  = 16;
    localparam int REGEN_BIT   = 68;

    typedef enum logic [1:0] {
        DRV_ZERO   = 2'b00,
        DRV_TILE   = 2'b01,
        DRV_POOL   = 2'b10,
        DRV_POOL_N = 2'b11
    } drv_mode_t;

    // Driver word is {mode[1:0], src[7:0]}; src indexes the shared pool.
    function automatic logic drive_bit(input logic [DRV_BITS-1:0] drv,
                                       input logic                tile_out,
                                       input logic [POOL_BITS-1:0] pool);
        logic res;
        res = 1'b0;
        case (drv_mode_t'(drv[9:8]))
            DRV_ZERO:   res = 1'b0;
            DRV_TILE:   res = tile_out;
            DRV_POOL:   res = pool[drv[7:0]];
            DRV_POOL_N: res = ~pool[drv[7:0]];
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fpga_core_if.sv
// rtl/fpga_core_if.sv - programming and primary I/O bundle of the logic fabric
interface fpga_core_if;
    logic        prog_en;
    logic        prog_in;
    logic        prog_out;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] in3;
    logic [31:0] in4;
    logic [31:0] out1;
    logic [31:0] out2;
    logic [31:0] out3;
    logic [31:0] out4;

    modport master (
        output prog_en, prog_in, in1, in2, in3, in4,
        input  prog_out, out1, out2, out3, out4
    );

    modport slave (
        input  prog_en, prog_in, in1, in2, in3, in4,
        output prog_out, out1, out2, out3, out4
    );
endinterface

// File: rtl/fpga_tile.sv
// rtl/fpga_tile.sv - one logic tile: 4-LUT, optional flop, two output drivers
module fpga_tile
    import fpga_core_pkg::*;
(
    input  logic                 clb_clk,
    input  logic                 rst,
    input  logic                 prog_en,
    input  logic [TILE_BITS-1:0] cfg,
    input  logic [POOL_BITS-1:0] pool,
    output logic                 q,
    output logic                 drv_a,
    output logic                 drv_b
);

    logic [3:0]            lut_idx;
    logic [TRUTH_BITS-1:0] truth;
    logic                  lut_out;
    logic                  tile_out;

    always_comb begin
        lut_idx = '0;
        for (int j = 0; j < 4; j++) begin
            lut_idx[j] = pool[cfg[SEL_LSB + SEL_BITS*j +: SEL_BITS]];
        end
        truth    = cfg[TRUTH_LSB +: TRUTH_BITS];
        lut_out  = truth[lut_idx];
        tile_out = cfg[REGEN_BIT] ? q : lut_out;
        drv_a    = drive_bit(cfg[DRV_A_LSB +: DRV_BITS], tile_out, pool);
        drv_b    = drive_bit(cfg[DRV_B_LSB +: DRV_BITS], tile_out, pool);
    end

    // Flop is held clear while the bitstream is moving so stale state never leaks out.
    always_ff @(posedge clb_clk) begin
        if (rst || prog_en) begin
            q <= 1'b0;
        end else begin
            q <= lut_out;
        end
    end

endmodule

// File: rtl/fpga_core.sv
// rtl/fpga_core.sv - 64-tile programmable fabric with serial config chain
module fpga_core
    import fpga_core_pkg::*;
(
    input  logic        clb_clk,
    input  logic        rst,
    fpga_core_if.slave  bus
);

    logic [CFG_BITS-1:0]  cfg;
    logic [POOL_BITS-1:0] pool;
    logic [N_TILES-1:0]   q_vec;
    logic [N_TILES-1:0]   drv_a_vec;
    logic [N_TILES-1:0]   drv_b_vec;
    logic [IO_BITS-1:0]   out_bits;

    always_ff @(posedge clb_clk) begin
        if (rst) begin
            cfg <= '0;
        end else if (bus.prog_en) begin
            cfg <= {bus.prog_in, cfg[CFG_BITS-1:1]};
        end
    end

    assign bus.prog_out = cfg[0];

    // Feedback only enters the pool through tile flops, so there is no combinational loop.
    assign pool = {{(POOL_BITS-POOL_Q_BASE-N_TILES){1'b0}}, q_vec,
                   bus.in4, bus.in3, bus.in2, bus.in1};

    for (genvar t = 0; t < N_TILES; t++) begin : g_tile
        fpga_tile u_tile (
            .clb_clk (clb_clk),
            .rst     (rst),
            .prog_en (bus.prog_en),
            .cfg     (cfg[TILE_BITS*t +: TILE_BITS]),
            .pool    (pool),
            .q       (q_vec[t]),
            .drv_a   (drv_a_vec[t]),
            .drv_b   (drv_b_vec[t])
        );
    end

    always_comb begin
        out_bits = '0;
        for (int t = 0; t < N_TILES; t++) begin
            out_bits[2*t]   = drv_a_vec[t];
            out_bits[2*t+1] = drv_b_vec[t];
        end
    end

    assign {bus.out4, bus.out3, bus.out2, bus.out1} = out_bits;

endmodule

// File: tb/tb_fpga_core.sv
// tb/tb_fpga_core.sv - vector table, directed sequences and random model check for fpga_core
module tb_fpga_core;

    localparam int NB = 4416;

    logic clb_clk = 1'b0;
    logic rst;
    always #5 clb_clk = ~clb_clk;

    fpga_core_if bus ();

    fpga_core dut (
        .clb_clk (clb_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [NB-1:0]  mcfg;
    logic [63:0]    mq;
    logic [127:0]   ins;
    logic [NB-1:0]  cfg_lib [4];

    typedef struct {
        int          cfg_id;
        logic [31:0] in1;
        logic [31:0] exp_out1;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] get_out();
        return {bus.out4, bus.out3, bus.out2, bus.out1};
    endfunction

    task automatic set_in(input logic [127:0] v);
        {bus.in4, bus.in3, bus.in2, bus.in1} = v;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NB-1:0] rand_cfg();
        logic [NB-1:0] x;
        x = '0;
        for (int i = 0; i < NB/32; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    function automatic logic [68:0] slice(input logic regen, input logic [15:0] truth,
                                          input logic [7:0] s3, input logic [7:0] s2,
                                          input logic [7:0] s1, input logic [7:0] s0,
                                          input logic [9:0] db, input logic [9:0] da);
        return {regen, truth, s3, s2, s1, s0, db, da};
    endfunction

    function automatic logic [NB-1:0] tile0_cfg(input logic [68:0] s);
        logic [NB-1:0] x;
        x = '0;
        x[68:0] = s;
        return x;
    endfunction

    // Reference: pool = {zeros, Q, inputs}; each tile reads its 69-bit field of the bitstream.
    function automatic logic m_lut(input logic [68:0] c, input logic [255:0] p);
        logic [3:0]  idx;
        logic [15:0] tt;
        for (int j = 0; j < 4; j++) idx[j] = p[c[20+8*j +: 8]];
        tt = c[67:52];
        return tt[idx];
    endfunction

    function automatic logic [127:0] m_out(input logic [NB-1:0] c, input logic [127:0] in_v,
                                           input logic [63:0] q);
        logic [255:0] p;
        logic [127:0] o;
        logic [68:0]  tc;
        logic [9:0]   drv;
        logic         to;
        p = {64'b0, q, in_v};
        o = '0;
        for (int k = 0; k < 128; k++) begin
            tc  = c[69*(k/2) +: 69];
            drv = (k % 2 == 1) ? tc[19:10] : tc[9:0];
            to  = tc[68] ? q[k/2] : m_lut(tc, p);
            case (drv[9:8])
                2'd0: o[k] = 1'b0;
                2'd1: o[k] = to;
                2'd2: o[k] = p[drv[7:0]];
                default: o[k] = ~p[drv[7:0]];
            endcase
        end
        return o;
    endfunction

    function automatic logic [63:0] m_next_q(input logic [NB-1:0] c, input logic [127:0] in_v,
                                             input logic [63:0] q);
        logic [63:0] n;
        for (int t = 0; t < 64; t++) n[t] = m_lut(c[69*t +: 69], {64'b0, q, in_v});
        return n;
    endfunction

    task automatic load_cfg(input logic [NB-1:0] x);
        for (int i = 0; i < NB; i++) begin
            bus.prog_en = 1'b1;
            bus.prog_in = x[i];
            @(posedge clb_clk); #1;
        end
        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
        mcfg = x;
        mq   = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] pat;
        logic [63:0]   nq;
        int            errs;

        cfg_lib[0] = '0;
        cfg_lib[1] = tile0_cfg(slice(1'b0, 16'h0000, 8'd0, 8'd0, 8'd0, 8'd0, 10'h000, 10'h200));
        cfg_lib[2] = tile0_cfg(slice(1'b0, 16'h0008, 8'd192, 8'd192, 8'd1, 8'd0, 10'h000, 10'h100));
        cfg_lib[3] = tile0_cfg(slice(1'b0, 16'h0000, 8'd0, 8'd0, 8'd0, 8'd0, 10'h305, 10'h000));

        vecs[0] = '{0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 32'hFFFFFFFF, 32'h0};
        vecs[2] = '{1, 32'h00000001, 32'h1};
        vecs[3] = '{1, 32'h00000000, 32'h0};
        vecs[4] = '{1, 32'hFFFFFFFE, 32'h0};
        vecs[5] = '{2, 32'h00000003, 32'h1};
        vecs[6] = '{2, 32'h00000001, 32'h0};
        vecs[7] = '{2, 32'h00000002, 32'h0};
        vecs[8] = '{3, 32'h00000000, 32'h2};
        vecs[9] = '{3, 32'h00000020, 32'h0};

        rst = 1'b1;
        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
        set_in(rand128());
        repeat (2) @(posedge clb_clk);
        #1;
        rst = 1'b0;
        check("reset_outputs", get_out(), 128'h0);
        check("reset_prog_out", 128'(bus.prog_out), 128'h0);

        for (int i = 0; i < 10; i++) begin
            if (i == 0 || vecs[i].cfg_id != vecs[i-1].cfg_id) load_cfg(cfg_lib[vecs[i].cfg_id]);
            set_in({rand128() >> 32, vecs[i].in1} & {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hFFFFFFFF});
            #1;
            check($sformatf("vec%0d", i), get_out(), {96'b0, vecs[i].exp_out1});
            check($sformatf("vec%0d_prog_out", i), 128'(bus.prog_out), 128'(mcfg[0]));
            @(posedge clb_clk); #1;
        end

        // Registered AND: output follows inputs one edge late.
        load_cfg(tile0_cfg(slice(1'b1, 16'h0008, 8'd192, 8'd192, 8'd1, 8'd0, 10'h000, 10'h100)));
        set_in(128'h0);
        @(posedge clb_clk); #1;
        check("reg_idle", 128'(bus.out1[0]), 128'h0);
        set_in(128'h3);
        #1;
        check("reg_same_cycle", 128'(bus.out1[0]), 128'h0);
        @(posedge clb_clk); #1;
        check("reg_next_edge", 128'(bus.out1[0]), 128'h1);
        set_in(128'h0);
        #1;
        check("reg_hold", 128'(bus.out1[0]), 128'h1);
        @(posedge clb_clk); #1;
        check("reg_fall", 128'(bus.out1[0]), 128'h0);

        // Daisy chain: a second full pass replays the first bitstream, bit 0 first.
        pat = rand_cfg();
        load_cfg(pat);
        check("daisy_first_bit", 128'(bus.prog_out), 128'(pat[0]));
        errs = 0;
        for (int i = 0; i < NB; i++) begin
            if (bus.prog_out !== pat[i]) errs++;
            bus.prog_en = 1'b1;
            bus.prog_in = 1'($urandom);
            @(posedge clb_clk); #1;
        end
        bus.prog_en = 1'b0;
        check("daisy_replay_errors", 128'(errs), 128'h0);

        // Reset mid-run clears both config and outputs; reprogramming restores function.
        load_cfg(cfg_lib[2]);
        set_in(128'h3);
        #1;
        check("midrst_before", 128'(bus.out1[0]), 128'h1);
        rst = 1'b1;
        bus.prog_en = 1'b1;
        bus.prog_in = 1'b1;
        @(posedge clb_clk); #1;
        rst = 1'b0;
        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
        check("midrst_out", get_out(), 128'h0);
        check("midrst_prog_out", 128'(bus.prog_out), 128'h0);
        @(posedge clb_clk); #1;
        check("midrst_stays_zero", get_out(), 128'h0);
        load_cfg(cfg_lib[2]);
        set_in(128'h3);
        #1;
        check("midrst_reprog", get_out(), 128'h1);

        // Random bitstreams against the model, with a stray one-bit shift mid-run.
        for (int r = 0; r < 2; r++) begin
            load_cfg(rand_cfg());
            for (int c = 0; c < 150; c++) begin
                ins = rand128();
                set_in(ins);
                #1;
                check($sformatf("rand%0d_c%0d", r, c), get_out(), m_out(mcfg, ins, mq));
                check($sformatf("rand%0d_c%0d_prog_out", r, c), 128'(bus.prog_out), 128'(mcfg[0]));
                if (c == 75) begin
                    bus.prog_en = 1'b1;
                    bus.prog_in = 1'($urandom);
                    nq = '0;
                    @(posedge clb_clk); #1;
                    mcfg = {bus.prog_in, mcfg[NB-1:1]};
                    bus.prog_en = 1'b0;
                end else begin
                    nq = m_next_q(mcfg, ins, mq);
                    @(posedge clb_clk); #1;
                end
                mq = nq;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
